// File: rtl/sensor_cmd_pkg.sv
// Shared command/response codes and scheduler state encoding for the DHT11 request path.
package sensor_cmd_pkg;

   localparam logic [7:0] CmdReadHum   = 8'h01;
   localparam logic [7:0] CmdReadTemp  = 8'h02;
   localparam logic [7:0] CmdStatus    = 8'h03;
   localparam logic [7:0] CmdContTemp  = 8'h04;
   localparam logic [7:0] CmdContHum   = 8'h05;
   localparam logic [7:0] CmdStopCont  = 8'h06;

   localparam logic [7:0] RespOk        = 8'h07;
   localparam logic [7:0] RespHum       = 8'h08;
   localparam logic [7:0] RespTemp      = 8'h09;
   localparam logic [7:0] RespContTemp  = 8'h0A;
   localparam logic [7:0] RespContHum   = 8'h0B;
   localparam logic [7:0] RespContStop  = 8'h0C;
   localparam logic [7:0] RespSensorErr = 8'h1F;
   localparam logic [7:0] RespBadCmd    = 8'hEE;
   localparam logic [7:0] RespBadAddr   = 8'hEF;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StWaitGap,
      StStart,
      StWaitSensor,
      StRespond
   } sched_state_e;

   // Continuous-mode commands only count as known when that feature is built.
   function automatic logic cmd_is_known(input logic [7:0] cmd, input logic cont_en);
      if (cmd inside {CmdReadHum, CmdReadTemp, CmdStatus}) return 1'b1;
      if (cmd inside {CmdContTemp, CmdContHum, CmdStopCont}) return cont_en;
      return 1'b0;
   endfunction

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating cycle counter with synchronous clear and a ">= THRESHOLD" flag.
module sat_cycle_counter #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned THRESHOLD  = 1,
   parameter bit          RESET_FULL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic reached
);

   logic [WIDTH-1:0] count_q;

   // Count up while enabled, stick at all-ones so long waits never wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= RESET_FULL ? '1 : '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign reached = (count_q >= WIDTH'(THRESHOLD));

endmodule

// File: rtl/sensor_request_scheduler.sv
// Sequences DHT11 reads for decoded UART requests and returns one response per access.
// Build option: define SENSOR_CONT_MODE_EN to add periodic continuous re-reads (cmds 0x04-0x06).
module sensor_request_scheduler
   import sensor_cmd_pkg::*;
#(
   parameter int unsigned MIN_GAP_CYCLES     = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES     = 50_000_000,
   parameter int unsigned CONT_PERIOD_CYCLES = 100_000_000,
   parameter int unsigned NUM_SENSORS        = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] request_command,
   input  logic [7:0] request_address,
   output logic       sensor_start,
   input  logic       sensor_done,
   input  logic       sensor_error,
   input  logic [7:0] hum_int,
   input  logic [7:0] temp_int,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] response_command,
   output logic [7:0] response_value
);

`ifdef SENSOR_CONT_MODE_EN
   localparam logic ContEn = 1'b1;
`else
   localparam logic ContEn = 1'b0;
`endif

   sched_state_e state_q, state_d;
   logic [7:0]   cmd_q, cmd_d, addr_q, addr_d;
   logic [7:0]   resp_cmd_q, resp_cmd_d, resp_val_q, resp_val_d;
   logic         gap_clear, gap_reached, tmo_clear, tmo_reached;
   logic         cont_q, cont_d, cont_temp_q, cont_temp_d, period_clear, period_reached;

   // Gap counter starts saturated so the first read after reset is not held off.
   sat_cycle_counter #(.THRESHOLD(MIN_GAP_CYCLES), .RESET_FULL(1'b1)) u_gap (
      .clock  (clock),
      .reset  (reset),
      .clear  (gap_clear),
      .enable (1'b1),
      .reached(gap_reached)
   );

   sat_cycle_counter #(.THRESHOLD(TIMEOUT_CYCLES), .RESET_FULL(1'b0)) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (state_q == StWaitSensor),
      .reached(tmo_reached)
   );

`ifdef SENSOR_CONT_MODE_EN
   sat_cycle_counter #(.THRESHOLD(CONT_PERIOD_CYCLES), .RESET_FULL(1'b0)) u_period (
      .clock  (clock),
      .reset  (reset),
      .clear  (period_clear),
      .enable (cont_q),
      .reached(period_reached)
   );

   // Continuous flag and kind persist across transactions; only stop or reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_q      <= 1'b0;
         cont_temp_q <= 1'b0;
      end else begin
         cont_q      <= cont_d;
         cont_temp_q <= cont_temp_d;
      end
   end
`else
   assign cont_q         = 1'b0;
   assign cont_temp_q    = 1'b0;
   assign period_reached = 1'b0;
   logic unused_cont;
   assign unused_cont = ^{cont_d, cont_temp_d, period_clear, CONT_PERIOD_CYCLES};
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Latched request and response registers; response holds its value after the handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q      <= '0;
         addr_q     <= '0;
         resp_cmd_q <= '0;
         resp_val_q <= '0;
      end else begin
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         resp_cmd_q <= resp_cmd_d;
         resp_val_q <= resp_val_d;
      end
   end

   // Next state plus datapath updates decided in each state.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      resp_cmd_d   = resp_cmd_q;
      resp_val_d   = resp_val_q;
      cont_d       = cont_q;
      cont_temp_d  = cont_temp_q;
      gap_clear    = 1'b0;
      tmo_clear    = 1'b0;
      period_clear = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A real request beats a due re-read; the saturated period tick stays pending.
            if (req_valid) begin
               cmd_d   = request_command;
               addr_d  = request_address;
               state_d = StCheck;
            end else if (cont_q && period_reached) begin
               cmd_d        = cont_temp_q ? CmdContTemp : CmdContHum;
               addr_d       = '0;
               period_clear = 1'b1;
               state_d      = StWaitGap;
            end
         end
         StCheck: begin
            if (32'(addr_q) >= NUM_SENSORS) begin
               resp_cmd_d = RespBadAddr;
               resp_val_d = 8'h00;
               state_d    = StRespond;
            end else if (!cmd_is_known(cmd_q, ContEn)) begin
               resp_cmd_d = RespBadCmd;
               resp_val_d = 8'h00;
               state_d    = StRespond;
            end else if (cmd_q == CmdStopCont) begin
               cont_d     = 1'b0;
               resp_cmd_d = RespContStop;
               resp_val_d = 8'h00;
               state_d    = StRespond;
            end else begin
               state_d = StWaitGap;
            end
         end
         StWaitGap: begin
            if (gap_reached) state_d = StStart;
         end
         StStart: begin
            tmo_clear = 1'b1;
            state_d   = StWaitSensor;
         end
         StWaitSensor: begin
            if (sensor_error || tmo_reached) begin
               resp_cmd_d = RespSensorErr;
               resp_val_d = 8'h00;
               gap_clear  = 1'b1;
               state_d    = StRespond;
            end else if (sensor_done) begin
               gap_clear = 1'b1;
               state_d   = StRespond;
               unique case (cmd_q)
                  CmdReadHum: begin
                     resp_cmd_d = RespHum;
                     resp_val_d = hum_int;
                  end
                  CmdReadTemp: begin
                     resp_cmd_d = RespTemp;
                     resp_val_d = temp_int;
                  end
                  CmdContTemp: begin
                     resp_cmd_d   = RespContTemp;
                     resp_val_d   = temp_int;
                     cont_d       = 1'b1;
                     cont_temp_d  = 1'b1;
                     period_clear = 1'b1;
                  end
                  CmdContHum: begin
                     resp_cmd_d   = RespContHum;
                     resp_val_d   = hum_int;
                     cont_d       = 1'b1;
                     cont_temp_d  = 1'b0;
                     period_clear = 1'b1;
                  end
                  default: begin
                     resp_cmd_d = RespOk;
                     resp_val_d = 8'h00;
                  end
               endcase
            end
         end
         StRespond: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are forced inactive while reset is asserted.
   always_comb begin
      req_ready        = !reset && (state_q == StIdle);
      sensor_start     = !reset && (state_q == StStart);
      resp_valid       = !reset && (state_q == StRespond);
      response_command = resp_cmd_q;
      response_value   = resp_val_q;
   end

endmodule
